// File: rtl/flex_spi_slave.sv
// rtl/flex_spi_slave.sv - SPI responder: oversampled ss/sck/mosi, 4 modes, 1..DATA_W-bit frames, shared data bus
module flex_spi_slave #(
    parameter int DATA_W = 16,
    parameter int LEN_W  = 4,
    parameter int SYNC   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              ss,
    input  logic              sck,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_en,
    input  logic              cpol,
    input  logic              cpha,
    input  logic [LEN_W-1:0]  xfer_len,
    input  logic              we,
    input  logic              oe,
    inout  wire  [DATA_W-1:0] data,
    output logic              busy,
    output logic              done
);
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] DW = CNT_W'(DATA_W);

    typedef enum logic [1:0] {IDLE, XFER, HOLD} state_t;
    state_t state, state_nx;

    logic [SYNC-1:0]   ss_q, sck_q, mosi_q;
    logic              ss_prev, sck_prev;
    logic              ss_s, sck_s, mosi_s;
    logic              cpol_l, cpha_l;
    logic [CNT_W-1:0]  n_l, n_new, cnt;
    logic [DATA_W-1:0] tx_reg, rx_reg, tx_sh, rx_sh;
    logic [DATA_W-1:0] tx_align, rx_next, rx_mask;
    logic              sck_edge, lead, trail, sample_e, shift_e;
    logic              start, finish;

    assign ss_s    = ss_q[SYNC-1];
    assign sck_s   = sck_q[SYNC-1];
    assign mosi_s  = mosi_q[SYNC-1];
    assign data    = oe ? rx_reg : 'z;
    assign busy    = (state != IDLE);
    assign miso_en = (state != IDLE) && en;

    always_ff @(posedge clk) begin
        if (rst) begin
            ss_q     <= '1;
            sck_q    <= {SYNC{cpol}};
            mosi_q   <= '0;
            ss_prev  <= 1'b1;
            sck_prev <= cpol;
        end else begin
            ss_q     <= {ss_q[SYNC-2:0], ss};
            sck_q    <= {sck_q[SYNC-2:0], sck};
            mosi_q   <= {mosi_q[SYNC-2:0], mosi};
            ss_prev  <= ss_s;
            sck_prev <= sck_s;
        end
    end

    // tx word is left-aligned so the first bit to send always sits at the MSB
    always_comb begin
        n_new    = (xfer_len == '0) ? DW : CNT_W'(xfer_len);
        tx_align = tx_reg << (DW - n_new);
        rx_next  = {rx_sh[DATA_W-2:0], mosi_s};
        rx_mask  = ~({DATA_W{1'b1}} << n_l);
        sck_edge = sck_s ^ sck_prev;
        lead     = sck_edge & (sck_s ^ cpol_l);
        trail    = sck_edge & ~(sck_s ^ cpol_l);
        sample_e = cpha_l ? trail : lead;
        shift_e  = cpha_l ? lead : trail;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        start    = 1'b0;
        finish   = 1'b0;
        case (state)
            IDLE: if (en && ss_prev && !ss_s) begin
                start    = 1'b1;
                state_nx = XFER;
            end
            XFER: begin
                if (!en || ss_s) begin
                    state_nx = IDLE;
                end else if (sample_e && (cnt == n_l - 1'b1)) begin
                    finish   = 1'b1;
                    state_nx = HOLD;
                end
            end
            HOLD: if (!en || ss_s) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_reg <= '0;
            rx_reg <= '0;
            tx_sh  <= '0;
            rx_sh  <= '0;
            cnt    <= '0;
            n_l    <= '0;
            cpol_l <= 1'b0;
            cpha_l <= 1'b0;
            miso   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= finish;
            if (state == IDLE && we && !oe)
                tx_reg <= data;
            if (start) begin
                cpol_l <= cpol;
                cpha_l <= cpha;
                n_l    <= n_new;
                cnt    <= '0;
                rx_sh  <= '0;
                if (!cpha) begin
                    miso  <= tx_align[DATA_W-1];
                    tx_sh <= tx_align << 1;
                end else begin
                    tx_sh <= tx_align;
                end
            end else if (state == XFER) begin
                if (state_nx == IDLE) begin
                    cnt <= '0;
                end else begin
                    if (shift_e) begin
                        miso  <= tx_sh[DATA_W-1];
                        tx_sh <= tx_sh << 1;
                    end
                    if (sample_e) begin
                        rx_sh <= rx_next;
                        cnt   <= cnt + 1'b1;
                    end
                    if (finish)
                        rx_reg <= rx_next & rx_mask;
                end
            end
        end
    end
endmodule

// File: tb/tb_flex_spi_slave.sv
// tb/tb_flex_spi_slave.sv - randomized self-checking bench for flex_spi_slave
module tb_flex_spi_slave;
    localparam int H    = 6;
    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        rst, en, ss, sck, mosi, cpol, cpha, we, oe;
    logic [3:0]  xfer_len;
    logic [15:0] drv;
    logic        drv_en;
    wire  [15:0] data;
    logic        miso, miso_en, busy, done;
    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;

    assign data = drv_en ? drv : 'z;

    flex_spi_slave #(.DATA_W(16), .LEN_W(4), .SYNC(SYNC)) dut (
        .clk(clk), .rst(rst), .en(en), .ss(ss), .sck(sck), .mosi(mosi),
        .miso(miso), .miso_en(miso_en), .cpol(cpol), .cpha(cpha),
        .xfer_len(xfer_len), .we(we), .oe(oe), .data(data),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (done === 1'b1) done_cnt++;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] low_bits(input logic [31:0] v, input int n);
        return v & ((32'd1 << n) - 32'd1);
    endfunction

    task automatic set_mode(input logic p, input logic h, input int len);
        cpol = p; cpha = h; xfer_len = 4'(len); sck = p;
        tick(H);
    endtask

    task automatic load_tx(input logic [15:0] v);
        drv = v; drv_en = 1'b1; we = 1'b1;
        tick(1);
        we = 1'b0; drv_en = 1'b0;
    endtask

    task automatic read_rx(output logic [15:0] r);
        oe = 1'b1;
        tick(1);
        r = data;
        oe = 1'b0;
        tick(1);
    endtask

    // Master side: nb bit periods, mosi bits w[nb-1:0] MSB-first, miso captured on each sample edge
    task automatic clock_bits(input int nb, input logic [31:0] w, output logic [31:0] cap);
        cap = '0;
        for (int i = 0; i < nb; i++) begin
            if (!cpha) begin
                mosi = w[nb-1-i];
                tick(2);
                cap = {cap[30:0], miso};
                sck = ~cpol;
                tick(H);
                sck = cpol;
                tick(H);
            end else begin
                sck = ~cpol;
                mosi = w[nb-1-i];
                tick(H);
                cap = {cap[30:0], miso};
                sck = cpol;
                tick(H);
            end
        end
    endtask

    task automatic xfer(input int nb, input logic [31:0] w, output logic [31:0] cap);
        ss = 1'b0;
        tick(H);
        clock_bits(nb, w, cap);
        ss = 1'b1;
        tick(2 * H);
    endtask

    task automatic run_frame(input logic p, input logic h, input int len, input logic [15:0] tx,
                             input logic [31:0] w, input int nb,
                             output logic [31:0] cap, output logic [15:0] rx, output int dn);
        int d0;
        set_mode(p, h, len);
        load_tx(tx);
        d0 = done_cnt;
        xfer(nb, w, cap);
        dn = done_cnt - d0;
        read_rx(rx);
    endtask

    logic [31:0] cap, w;
    logic [15:0] rx, rx_prev, tx;
    int          dn, d0, n, len;
    logic        p, h;

    initial begin
        rst = 1'b1; en = 1'b1; ss = 1'b1; sck = 1'b0; mosi = 1'b0; cpol = 1'b0; cpha = 1'b0;
        xfer_len = '0; we = 1'b0; oe = 1'b0; drv = '0; drv_en = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(1);
        check("reset busy", 32'(busy), 0);
        check("reset done", 32'(done), 0);
        check("reset miso_en", 32'(miso_en), 0);
        check("reset miso", 32'(miso), 0);
        read_rx(rx);
        check("reset rx_reg", 32'(rx), 0);

        run_frame(1'b0, 1'b1, 12, 16'hAAAA, 32'h5A3, 12, cap, rx, dn);
        check("t1 miso", cap, 32'hAAA);
        check("t1 done", dn, 1);
        check("t1 rx", 32'(rx), 32'h05A3);

        for (int m = 0; m < 4; m++) begin
            run_frame(m[1], m[0], 0, 16'h7777, 32'hC3E1, 16, cap, rx, dn);
            check($sformatf("t2 miso mode%0d", m), cap, 32'h7777);
            check($sformatf("t2 rx mode%0d", m), 32'(rx), 32'hC3E1);
            check($sformatf("t2 done mode%0d", m), dn, 1);
        end

        for (int k = 0; k < 8; k++) begin
            p = 1'($urandom_range(0, 1)); h = 1'($urandom_range(0, 1));
            len = $urandom_range(0, 15); tx = 16'($urandom); w = 32'($urandom);
            n = (len == 0) ? 16 : len;
            run_frame(p, h, len, tx, w, n, cap, rx, dn);
            check($sformatf("rnd%0d miso", k), cap, low_bits(32'(tx), n));
            check($sformatf("rnd%0d rx", k), 32'(rx), low_bits(w, n));
            check($sformatf("rnd%0d done", k), dn, 1);
        end

        read_rx(rx_prev);
        set_mode(1'b0, 1'b0, 12);
        load_tx(16'h0F0F);
        d0 = done_cnt;
        ss = 1'b0;
        tick(H);
        clock_bits(2, 32'h3, cap);
        sck = ~cpol;
        tick(H);
        ss = 1'b1;
        tick(SYNC);
        check("t3 busy before drop", 32'(busy), 1);
        tick(1);
        check("t3 busy after drop", 32'(busy), 0);
        sck = cpol;
        tick(2 * H);
        check("t3 no done", done_cnt - d0, 0);
        read_rx(rx);
        check("t3 rx kept", 32'(rx), 32'(rx_prev));
        run_frame(1'b0, 1'b0, 12, 16'h0F0F, 32'hB6D, 12, cap, rx, dn);
        check("t3 next miso", cap, 32'hF0F);
        check("t3 next rx", 32'(rx), 32'h0B6D);
        check("t3 next done", dn, 1);

        set_mode(1'b1, 1'b0, 8);
        load_tx(16'h00C5);
        d0 = done_cnt;
        ss = 1'b0;
        tick(H);
        clock_bits(10, 32'h2D6, cap);
        check("t4 miso_en held", 32'(miso_en), 1);
        check("t4 busy held", 32'(busy), 1);
        ss = 1'b1;
        tick(2 * H);
        check("t4 done", done_cnt - d0, 1);
        check("t4 miso frozen", cap, 32'h317);
        read_rx(rx);
        check("t4 rx", 32'(rx), 32'h00B5);

        set_mode(1'b1, 1'b1, 0);
        load_tx(16'hBEEF);
        ss = 1'b0;
        tick(H);
        check("t5 busy", 32'(busy), 1);
        drv = 16'h1234; drv_en = 1'b1; we = 1'b1;
        tick(3);
        we = 1'b0; drv_en = 1'b0;
        clock_bits(16, 32'h1111, cap);
        ss = 1'b1;
        tick(2 * H);
        check("t5 miso old tx", cap, 32'hBEEF);
        xfer(16, 32'h2222, cap);
        check("t5 next miso old tx", cap, 32'hBEEF);

        set_mode(1'b0, 1'b1, 8);
        load_tx(16'h005C);
        d0 = done_cnt;
        ss = 1'b0;
        tick(H);
        clock_bits(3, 32'h5, cap);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("t6 rst busy", 32'(busy), 0);
        check("t6 rst miso_en", 32'(miso_en), 0);
        check("t6 rst miso", 32'(miso), 0);
        read_rx(rx);
        check("t6 rst rx", 32'(rx), 0);
        ss = 1'b1;
        tick(2 * H);
        load_tx(16'h00F0);
        ss = 1'b0;
        tick(H);
        check("t6 busy before en", 32'(busy), 1);
        clock_bits(3, 32'h2, cap);
        en = 1'b0;
        tick(2);
        check("t6 en busy", 32'(busy), 0);
        check("t6 en miso_en", 32'(miso_en), 0);
        en = 1'b1;
        tick(H);
        check("t6 no restart", 32'(busy), 0);
        check("t6 no done", done_cnt - d0, 0);
        ss = 1'b1;
        tick(2 * H);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
